// File: rtl/soc_run_ctrl.sv
// soc_run_ctrl: stretches reset into the SoC, then times the run and ends
// it on a to-host mailbox store, a stalled PC, or a cycle-budget timeout.
//
// Ports:
//   clk, rst          : clock and async active-high reset
//   pc_i              : SoC program counter (stall watchdog)
//   mem_we_i          : SoC data-memory write enable
//   mem_addr_i        : SoC data-memory address
//   mem_wdata_i       : SoC data-memory write data
//   soc_rst           : reset into the SoC (rises with rst)
//   running           : high in RUN
//   cycle_cnt         : RUN edges seen, frozen in DONE
//   done              : sticky, run finished
//   pass/fail         : sticky, mailbox store of 1 / other value
//   stall             : sticky, PC watchdog fired
//   timeout           : sticky, cycle budget used up
//   exit_code         : mailbox data >> 1, captured on the store
module soc_run_ctrl #(
  parameter int          RST_CYCLES   = 2,
  parameter int          MAX_CYCLES   = 500,
  parameter int          STALL_CYCLES = 64,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_FFF0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_i,
  input  logic             mem_we_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      mem_wdata_i,
  output logic             soc_rst,
  output logic             running,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             stall,
  output logic             timeout,
  output logic [31:0]      exit_code
);

  // Hold counter only needs to reach RST_CYCLES-1; the stall counter
  // fires as it would step to STALL_CYCLES-1, so it tops out one lower.
  localparam int HW =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SW =
    (STALL_CYCLES > 2) ? $clog2(STALL_CYCLES - 1) : 1;

  localparam logic [HW-1:0] HOLD_LAST =
    HW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STALL_LAST =
    SW'(STALL_CYCLES - 2);
  localparam logic [CNT_W-1:0] MAX_LAST =
    CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [HW-1:0]    r_hold_cnt;
  logic [SW-1:0]    r_stall_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [31:0]      r_prev_pc;
  logic [31:0]      r_exit_code;
  logic             r_soc_rst;
  logic             r_running;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;
  logic             r_stall;
  logic             r_timeout;

  logic             w_hit;
  logic             w_match;
  logic             w_stall;
  logic             w_tmo;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_hit = mem_we_i
    && (mem_addr_i == TOHOST_ADDR);

  // r_prev_pc holds a HOLD-phase PC during the first RUN cycle, so that
  // cycle (cycle_cnt still 0) is never treated as a repeat.
  assign w_match = (pc_i == r_prev_pc)
    && (r_cycle_cnt != '0);

  assign w_stall = w_match
    && (r_stall_cnt == STALL_LAST);

  assign w_tmo = (r_cycle_cnt == MAX_LAST);

  assign w_cnt_nxt = (r_cycle_cnt == '1)
    ? r_cycle_cnt
    : r_cycle_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_HOLD;
      r_hold_cnt  <= '0;
      r_stall_cnt <= '0;
      r_cycle_cnt <= '0;
      r_prev_pc   <= '0;
      r_exit_code <= '0;
      r_soc_rst   <= 1'b1;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_stall     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_prev_pc <= pc_i;
      unique case (r_state)
        S_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state   <= S_RUN;
            r_soc_rst <= 1'b0;
            r_running <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        S_RUN: begin
          r_cycle_cnt <= w_cnt_nxt;
          r_stall_cnt <= w_match
            ? r_stall_cnt + SW'(1)
            : '0;
          // Mailbox beats stall beats timeout, so
          // only one cause flag is ever raised.
          if (w_hit) begin
            r_state     <= S_DONE;
            r_running   <= 1'b0;
            r_done      <= 1'b1;
            r_exit_code <= {1'b0, mem_wdata_i[31:1]};
            if (mem_wdata_i == 32'd1) begin
              r_pass <= 1'b1;
            end else begin
              r_fail <= 1'b1;
            end
          end else if (w_stall) begin
            r_state   <= S_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_stall   <= 1'b1;
          end else if (w_tmo) begin
            r_state   <= S_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_HOLD;
        end
      endcase
    end
  end

  // rst reaches the SoC with no clock delay.
  assign soc_rst   = rst | r_soc_rst;
  assign running   = r_running;
  assign cycle_cnt = r_cycle_cnt;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign stall     = r_stall;
  assign timeout   = r_timeout;
  assign exit_code = r_exit_code;

endmodule

// File: tb/tb_soc_run_ctrl.sv
// tb_soc_run_ctrl: table of run scenarios for soc_run_ctrl with a
// result scoreboard, plus a hand-written reset-mid-run sequence.
module tb_soc_run_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        soc_rst;
  logic        running;
  logic [31:0] cycle_cnt;
  logic        done;
  logic        pass;
  logic        fail;
  logic        stall;
  logic        timeout;
  logic [31:0] exit_code;

  int n_chk;
  int n_err;

  soc_run_ctrl #(
    .RST_CYCLES   (2),
    .MAX_CYCLES   (20),
    .STALL_CYCLES (4),
    .CNT_W        (32),
    .TOHOST_ADDR  (32'h0000_FFF0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_i        (pc_i),
    .mem_we_i    (mem_we_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .soc_rst     (soc_rst),
    .running     (running),
    .cycle_cnt   (cycle_cnt),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .stall       (stall),
    .timeout     (timeout),
    .exit_code   (exit_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          wr_cyc;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    int          decoy_cyc;
    int          stall_from;
    bit          hold_wr;
    bit          e_pass;
    bit          e_fail;
    bit          e_stall;
    bit          e_tmo;
    logic [31:0] e_cnt;
    logic [31:0] e_exit;
  } vec_t;

  typedef struct packed {
    logic        p;
    logic        f;
    logic        s;
    logic        t;
    logic [31:0] cnt;
    logic [31:0] ex;
  } res_t;

  res_t sb_q[$];
  vec_t vecs[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Assert rst from any state, check the forced values, release on the
  // next falling edge and follow the two HOLD edges.
  task automatic do_reset(input bit hold_wr);
    @(negedge clk);
    rst = 1'b1;
    mem_we_i = 1'b0;
    pc_i = 32'h0;
    #1;
    chk("rst_soc_rst", {31'd0, soc_rst}, 32'd1);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_flags", {28'd0, pass, fail, stall, timeout}, 32'd0);
    chk("rst_cnt", cycle_cnt, 32'd0);
    chk("rst_exit", exit_code, 32'd0);
    @(negedge clk);
    if (hold_wr) begin
      mem_we_i = 1'b1;
      mem_addr_i = 32'h0000_FFF0;
      mem_wdata_i = 32'd1;
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("edge1_soc_rst", {31'd0, soc_rst}, 32'd1);
    chk("edge1_running", {31'd0, running}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_we_i = 1'b0;
    chk("edge2_soc_rst", {31'd0, soc_rst}, 32'd0);
    chk("edge2_running", {31'd0, running}, 32'd1);
    chk("edge2_cnt", cycle_cnt, 32'd0);
    chk("edge2_flags",
        {27'd0, done, pass, fail, stall, timeout}, 32'd0);
  endtask

  task automatic drive(input vec_t v, input int k);
    if (v.stall_from != 0 && k >= v.stall_from)
      pc_i = 32'h40;
    else
      pc_i = 32'h100 + 32'(4 * k);
    mem_we_i = 1'b0;
    mem_addr_i = 32'h0;
    mem_wdata_i = 32'h0;
    if (k == v.decoy_cyc) begin
      mem_we_i = 1'b1;
      mem_addr_i = 32'h0000_FFF4;
      mem_wdata_i = 32'd1;
    end
    if (k == v.wr_cyc) begin
      mem_we_i = 1'b1;
      mem_addr_i = v.wr_addr;
      mem_wdata_i = v.wr_data;
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    res_t exp;
    res_t got;
    int   k;
    bit   fin;
    do_reset(v.hold_wr);
    exp.p = v.e_pass;
    exp.f = v.e_fail;
    exp.s = v.e_stall;
    exp.t = v.e_tmo;
    exp.cnt = v.e_cnt;
    exp.ex = v.e_exit;
    sb_q.push_back(exp);
    k = 0;
    fin = 1'b0;
    while (!fin && k < 40) begin
      k++;
      drive(v, k);
      @(posedge clk);
      @(negedge clk);
      if (done) fin = 1'b1;
    end
    mem_we_i = 1'b0;
    exp = sb_q.pop_front();
    if (!fin) begin
      n_chk++;
      n_err++;
      $display("FAIL v%0d done_wait got 0 want 1", id);
    end else begin
      got.p = pass;
      got.f = fail;
      got.s = stall;
      got.t = timeout;
      got.cnt = cycle_cnt;
      got.ex = exit_code;
      chk($sformatf("v%0d pass", id), {31'd0, got.p}, {31'd0, exp.p});
      chk($sformatf("v%0d fail", id), {31'd0, got.f}, {31'd0, exp.f});
      chk($sformatf("v%0d stall", id), {31'd0, got.s}, {31'd0, exp.s});
      chk($sformatf("v%0d timeout", id), {31'd0, got.t}, {31'd0, exp.t});
      chk($sformatf("v%0d cnt", id), got.cnt, exp.cnt);
      chk($sformatf("v%0d exit", id), got.ex, exp.ex);
      chk($sformatf("v%0d running", id), {31'd0, running}, 32'd0);
      repeat (3) begin
        pc_i = pc_i + 32'd4;
        @(posedge clk);
        @(negedge clk);
      end
      chk($sformatf("v%0d frozen_cnt", id), cycle_cnt, exp.cnt);
      chk($sformatf("v%0d done_held", id), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d soc_rst_low", id), {31'd0, soc_rst}, 32'd0);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    pc_i = 32'h0;
    mem_we_i = 1'b0;
    mem_addr_i = 32'h0;
    mem_wdata_i = 32'h0;

    //          wr  addr          data          dcy stl hw  P  F  S  T  cnt exit
    vecs[0] = '{7,  32'h0000_FFF0, 32'h1,        0,  0,  0, 1, 0, 0, 0, 7,  32'h0};
    vecs[1] = '{9,  32'h0000_FFF0, 32'h7,        3,  0,  0, 0, 1, 0, 0, 9,  32'h3};
    vecs[2] = '{0,  32'h0,         32'h0,        0,  5,  0, 0, 0, 1, 0, 8,  32'h0};
    vecs[3] = '{0,  32'h0,         32'h0,        0,  0,  0, 0, 0, 0, 1, 20, 32'h0};
    vecs[4] = '{20, 32'h0000_FFF0, 32'h1,        0,  0,  0, 1, 0, 0, 0, 20, 32'h0};
    vecs[5] = '{8,  32'h0000_FFF0, 32'h10,       0,  5,  0, 0, 1, 0, 0, 8,  32'h8};
    vecs[6] = '{3,  32'h0000_FFF0, 32'hFFFF_FFFF, 0, 0,  1, 0, 1, 0, 0, 3,  32'h7FFF_FFFF};
    vecs[7] = '{0,  32'h0,         32'h0,        0,  17, 0, 0, 0, 1, 0, 20, 32'h0};

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset during RUN: abort at once, then a full HOLD again.
    do_reset(1'b0);
    for (int k = 1; k < 10; k++) begin
      pc_i = 32'h200 + 32'(4 * k);
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_cnt_before", cycle_cnt, 32'd9);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_soc_rst", {31'd0, soc_rst}, 32'd1);
    chk("mid_cnt_clr", cycle_cnt, 32'd0);
    chk("mid_running", {31'd0, running}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_edge1_soc_rst", {31'd0, soc_rst}, 32'd1);
    chk("mid_edge1_running", {31'd0, running}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_edge2_soc_rst", {31'd0, soc_rst}, 32'd0);
    chk("mid_edge2_running", {31'd0, running}, 32'd1);
    pc_i = 32'h300;
    @(posedge clk);
    @(negedge clk);
    chk("mid_cnt_restart", cycle_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/soc_run_ctrl.md
# soc_run_ctrl

Synthesizable run controller that replaces the fixed-delay stimulus in SoC benches with a parametrised, observable run sequence. It sits between the bench clock/reset and `soc_top`. It stretches reset for a programmable number of cycles and counts run cycles. It ends the run on one of three events: a write to a to-host mailbox address (pass/fail with exit code), a stalled program counter, or a cycle budget timeout.

## Interface
Parameters:
- `RST_CYCLES`, 2: cycles `soc_rst` stays high after `rst` deasserts (min 1).
- `MAX_CYCLES`, 500: run-cycle budget before timeout (min 1).
- `STALL_CYCLES`, 64: consecutive cycles of unchanged PC that flag a stall (min 2).
- `CNT_W`, 32: width of the cycle counter. Must hold `MAX_CYCLES`.
- `TOHOST_ADDR`, 32'h0000_FFF0: mailbox address for the end-of-test store.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pc_i` in 32: SoC program counter.
- `mem_we_i` in 1: SoC data-memory write enable.
- `mem_addr_i` in 32: SoC data-memory address.
- `mem_wdata_i` in 32: SoC data-memory write data.
- `soc_rst` out 1: reset driven into `soc_top`.
- `running` out 1: high while in RUN.
- `cycle_cnt` out CNT_W: number of RUN cycles completed.
- `done` out 1: sticky, run finished by any cause.
- `pass` out 1: sticky, mailbox write with value 1.
- `fail` out 1: sticky, mailbox write with any other value.
- `stall` out 1: sticky, PC watchdog fired.
- `timeout` out 1: sticky, cycle budget exhausted.
- `exit_code` out 32: `mem_wdata_i >> 1` captured at the mailbox write. 0 otherwise.

## Operation
- FSM has three states: HOLD, RUN, DONE.
- While `rst` is high, the FSM is asynchronously forced to HOLD, with:
  - `soc_rst` = 1
  - all counters = 0
  - `running`, `done`, `pass`, `fail`, `stall`, `timeout` = 0
  - `exit_code` = 0
- HOLD: a hold counter increments each edge. When it reaches `RST_CYCLES`, the FSM goes to RUN and `soc_rst` is 0 on that edge.
- RUN: `cycle_cnt` increments by 1 each edge. It saturates and never wraps.
- Mailbox hit: `mem_we_i` high with `mem_addr_i == TOHOST_ADDR`. On a hit:
  - FSM goes to DONE.
  - `pass` is set if `mem_wdata_i == 1`; otherwise `fail` is set.
  - `exit_code` captures `mem_wdata_i >> 1`.
- Writes to the mailbox outside RUN are ignored.
- Stall watchdog:
  - The previous `pc_i` is registered each cycle.
  - The stall counter increments when `pc_i` equals the registered value and resets to 0 otherwise.
  - When the counter reaches `STALL_CYCLES - 1`, `stall` is set and the FSM goes to DONE.
  - The first RUN cycle never counts as a match.
- Timeout: on the edge where `cycle_cnt` would become `MAX_CYCLES`, `timeout` is set and the FSM goes to DONE.
- Simultaneous events on one edge: priority is mailbox > stall > timeout. Exactly one cause flag is ever set.
- DONE:
  - `done` = 1, `running` = 0.
  - `cycle_cnt` freezes.
  - `soc_rst` stays 0, so the SoC keeps running for waveform capture.
  - Only `rst` leaves DONE.
- Reset asserted mid-RUN or mid-DONE aborts immediately and restarts the full HOLD sequence after release.

## Timing
- `soc_rst` rises combinationally with `rst`, with zero-cycle latency.
- `soc_rst` falls on the `RST_CYCLES`-th rising edge after `rst` deasserts.
- Cause flags, `done`, and `exit_code` are registered. They are visible one edge after the qualifying input cycle.
- The `running` fall and the `done` rise happen on the same edge.
- `cycle_cnt` equals the number of RUN edges. At timeout it reads `MAX_CYCLES`.
- No combinational path from SoC inputs to any output.

## Test plan
All scenarios use `RST_CYCLES`=2, `MAX_CYCLES`=20, `STALL_CYCLES`=4.
- Reset release: deassert `rst` at 20 ns with a 10 ns clock. `soc_rst` = 1 through edge 1 and 0 after edge 2. `running` = 1 after edge 2. All flags = 0.
- Pass: PC increments each cycle; at run cycle 7, write 32'h1 to 0xFFF0. Required: `done` = `pass` = 1, `exit_code` = 0, `cycle_cnt` frozen at 7.
- Fail: write 32'h7 to 0xFFF0. Required: `fail` = 1, `exit_code` = 3. Writes to 0xFFF4 are ignored.
- Stall: hold `pc_i` = 0x40 from run cycle 5. Required: `stall` = 1 after 4 equal-PC cycles, and `timeout` stays 0.
- Timeout: PC always changing, no mailbox write. Required: `timeout` = 1 with `cycle_cnt` = 20. The same edge with a mailbox write of 1 instead gives `pass` = 1 and `timeout` = 0.
- Reset mid-run: assert `rst` at run cycle 10 for 3 cycles. Required: `soc_rst` = 1 immediately, `cycle_cnt` = 0, and a full 2-cycle HOLD is redone after release.
